// File: rtl/frame_writer_pkg.sv
// Shared definitions for the camera-to-PSRAM frame writer.
//   - fw_state_e       : frame writer control states
//   - QUEUE_W          : width of a camera queue word (marker + RGB565 pixel)
//   - QUEUE_MARKER_BIT : bit flagging the first pixel slot of a new frame
//   - FRAME_*          : frame geometry, also used by camera_control_defs
package frame_writer_pkg;

  localparam int QUEUE_W          = 17;
  localparam int QUEUE_MARKER_BIT = 16;

  localparam int FRAME_PIX_W      = 640;
  localparam int FRAME_PIX_H      = 480;
  // Two RGB565 pixels per 32-bit memory word.
  localparam int FRAME_WORDS_DEF  = FRAME_PIX_W * FRAME_PIX_H / 2;

  typedef enum logic [2:0] {
    S_SYNC,
    S_FILL,
    S_CMD,
    S_DATA,
    S_FLIP
  } fw_state_e;

endpackage

// File: rtl/frame_writer_burst_buffer.sv
// Burst staging buffer: DEPTH x 32 simple dual-port RAM.
//   clk, rst       : clock, async active-high reset (pointers/count only)
//   clr            : drop contents and rewind both pointers
//   wr_en, wr_data : append one word
//   rd_adv         : step the read pointer to the next beat
//   rd_data        : word at the read pointer; zero past the filled words,
//                    which is how a short (flushed) burst gets padded
//   count          : words written since the last clear
//   rd_last        : read pointer sits on the final beat of the burst
module burst_buffer
  import frame_writer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [31:0]   wr_data,
  input  logic          rd_adv,
  output logic [31:0]   rd_data,
  output logic [CW-1:0] count,
  output logic          rd_last
);

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
        count_q  <= count_q + CW'(1);
      end
      if (rd_adv) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  assign rd_data = (CW'(rd_ptr_q) < count_q) ? mem_q[rd_ptr_q] : 32'h0;
  assign count   = count_q;
  assign rd_last = (rd_ptr_q == PW'(DEPTH - 1));

endmodule

// File: rtl/frame_writer.sv
// Memory-domain consumer of the camera pixel queue.
// Packs RGB565 pixel pairs into 32-bit words, stages them in a burst buffer
// and writes fixed-length bursts into a double-buffered frame store.
//   MemClk, RST          : clock, async active-high reset
//   fifo_empty/rd_en/data: queue FIFO read side (data one cycle after rd_en)
//   mem_cmd_*            : write-burst command (valid/ready, start address)
//   mem_wr_*             : write data beats (valid/ready)
//   frame_done/frame_buf : completion pulse and index of the finished buffer
//   overflow_err         : sticky, pixels dropped past the end of a frame
module frame_writer
  import frame_writer_pkg::*;
#(
  parameter int               ADDR_W      = 21,
  parameter int               BURST_WORDS = 8,   // power of two, 2..64
  parameter int               FRAME_WORDS = FRAME_WORDS_DEF,
  parameter logic [ADDR_W-1:0] BUF0_BASE  = '0,
  parameter logic [ADDR_W-1:0] BUF1_BASE  = ADDR_W'(FRAME_WORDS_DEF)
) (
  input  logic               MemClk,
  input  logic               RST,
  input  logic               fifo_empty,
  output logic               fifo_rd_en,
  input  logic [QUEUE_W-1:0] fifo_data,
  output logic               mem_cmd_valid,
  input  logic               mem_cmd_ready,
  output logic [ADDR_W-1:0]  mem_cmd_addr,
  output logic               mem_wr_valid,
  input  logic               mem_wr_ready,
  output logic [31:0]        mem_wr_data,
  output logic               frame_done,
  output logic               frame_buf,
  output logic               overflow_err
);

  localparam int CW = $clog2(BURST_WORDS + 1);
  localparam int RW = CW + 1;

  fw_state_e         state_q, state_d;
  logic              buf_idx_q, frame_buf_q, ovf_err_q;
  logic              rd_pend_q, half_q, flush_q;
  logic [15:0]       lo_q;
  logic [ADDR_W-1:0] addr_q;

  logic [ADDR_W-1:0] base_cur, base_nxt, frame_off;
  logic              q_vld, q_mark, fill_pix, fill_mark;
  logic              in_ovf, pending, room;
  logic [RW-1:0]     room_sum;
  logic              bb_wr_en, bb_clr, bb_last, beat_acc;
  logic [31:0]       bb_wr_data, bb_rd_data;
  logic [CW-1:0]     bb_count;

  // A word read last cycle is on fifo_data now.
  assign q_vld     = rd_pend_q;
  assign q_mark    = fifo_data[QUEUE_MARKER_BIT];
  assign fill_pix  = (state_q == S_FILL) && q_vld && !q_mark;
  assign fill_mark = (state_q == S_FILL) && q_vld &&  q_mark;

  assign base_cur  = buf_idx_q ? BUF1_BASE : BUF0_BASE;
  assign base_nxt  = buf_idx_q ? BUF0_BASE : BUF1_BASE;
  assign frame_off = addr_q - base_cur;
  assign in_ovf    = (frame_off >= ADDR_W'(FRAME_WORDS));
  assign pending   = half_q || (bb_count != '0);

  // Each in-flight read can complete at most one word, so reserve a slot
  // for it; the burst can then never overfill.
  assign room_sum  = {1'b0, bb_count} + RW'(rd_pend_q);
  assign room      = (room_sum < RW'(BURST_WORDS));

  // Second pixel of a pair completes a word; a marker with a half word
  // pending writes that half with a zero upper pixel.
  assign bb_wr_en   = half_q && ((fill_pix && !in_ovf) || fill_mark);
  assign bb_wr_data = {q_mark ? 16'h0 : fifo_data[15:0], lo_q};

  assign beat_acc = (state_q == S_DATA) && mem_wr_ready;
  assign bb_clr   = beat_acc && bb_last;

  burst_buffer #(.DEPTH(BURST_WORDS)) u_bbuf (
    .clk     (MemClk),
    .rst     (RST),
    .clr     (bb_clr),
    .wr_en   (bb_wr_en),
    .wr_data (bb_wr_data),
    .rd_adv  (beat_acc),
    .rd_data (bb_rd_data),
    .count   (bb_count),
    .rd_last (bb_last)
  );

  // State register
  always_ff @(posedge MemClk or posedge RST) begin
    if (RST) state_q <= S_SYNC;
    else     state_q <= state_d;
  end

  // Next state. A full burst is detected on the write itself so the
  // command goes out the very next cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_SYNC: if (q_vld && q_mark) state_d = S_FILL;
      S_FILL: begin
        if (fill_mark)
          state_d = pending ? S_CMD : S_FLIP;
        else if (bb_wr_en && (bb_count == CW'(BURST_WORDS - 1)))
          state_d = S_CMD;
      end
      S_CMD:  if (mem_cmd_ready) state_d = S_DATA;
      S_DATA: if (beat_acc && bb_last) state_d = flush_q ? S_FLIP : S_FILL;
      S_FLIP: state_d = S_FILL;
      default: state_d = S_SYNC;
    endcase
  end

  // Outputs. Reads stop while a marker is on fifo_data so nothing from the
  // next frame is in flight when FILL is left.
  always_comb begin
    fifo_rd_en    = 1'b0;
    mem_cmd_valid = 1'b0;
    mem_cmd_addr  = '0;
    mem_wr_valid  = 1'b0;
    mem_wr_data   = '0;
    frame_done    = 1'b0;
    frame_buf     = frame_buf_q;
    unique case (state_q)
      S_SYNC: fifo_rd_en = !fifo_empty;
      S_FILL: fifo_rd_en = !fifo_empty && room && !(q_vld && q_mark);
      S_CMD: begin
        mem_cmd_valid = 1'b1;
        mem_cmd_addr  = addr_q;
      end
      S_DATA: begin
        mem_wr_valid = 1'b1;
        mem_wr_data  = bb_rd_data;
      end
      S_FLIP: begin
        frame_done = 1'b1;
        frame_buf  = buf_idx_q;
      end
      default: ;
    endcase
    // Keep the read strobe low for the whole reset, not just after it.
    if (RST) fifo_rd_en = 1'b0;
  end

  assign overflow_err = ovf_err_q;

  // Datapath
  always_ff @(posedge MemClk or posedge RST) begin
    if (RST) begin
      rd_pend_q   <= 1'b0;
      half_q      <= 1'b0;
      lo_q        <= '0;
      flush_q     <= 1'b0;
      buf_idx_q   <= 1'b0;
      frame_buf_q <= 1'b0;
      ovf_err_q   <= 1'b0;
      addr_q      <= BUF0_BASE;
    end else begin
      rd_pend_q <= fifo_rd_en;
      unique case (state_q)
        S_SYNC: if (q_vld && q_mark) addr_q <= base_cur;
        S_FILL: begin
          if (fill_mark) begin
            half_q  <= 1'b0;
            flush_q <= pending;
          end else if (fill_pix) begin
            if (in_ovf) begin
              ovf_err_q <= 1'b1;
            end else begin
              half_q <= !half_q;
              if (!half_q) lo_q <= fifo_data[15:0];
            end
          end
        end
        S_DATA: if (beat_acc && bb_last) begin
          addr_q  <= addr_q + ADDR_W'(BURST_WORDS);
          flush_q <= 1'b0;
        end
        // Resetting the address to the new base also restarts the
        // per-frame overflow check.
        S_FLIP: begin
          frame_buf_q <= buf_idx_q;
          buf_idx_q   <= !buf_idx_q;
          addr_q      <= base_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_writer.sv
module tb_frame_writer;
  import frame_writer_pkg::*;

  localparam int AW = 21;
  localparam int BW = 8;
  localparam int FW = 64;
  localparam logic [AW-1:0] B0 = 21'd0;
  localparam logic [AW-1:0] B1 = 21'd153600;

  logic MemClk = 1'b0;
  logic RST;
  logic fifo_empty, fifo_rd_en;
  logic [QUEUE_W-1:0] fifo_data;
  logic mem_cmd_valid, mem_cmd_ready;
  logic [AW-1:0] mem_cmd_addr;
  logic mem_wr_valid, mem_wr_ready;
  logic [31:0] mem_wr_data;
  logic frame_done, frame_buf, overflow_err;

  always #5 MemClk = ~MemClk;

  frame_writer #(
    .ADDR_W(AW), .BURST_WORDS(BW), .FRAME_WORDS(FW),
    .BUF0_BASE(B0), .BUF1_BASE(B1)
  ) dut (
    .MemClk(MemClk), .RST(RST),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_data(fifo_data),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_addr(mem_cmd_addr),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
    .mem_wr_data(mem_wr_data),
    .frame_done(frame_done), .frame_buf(frame_buf), .overflow_err(overflow_err)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Queue FIFO contents and expected memory traffic.
  logic [QUEUE_W-1:0] fq[$];
  logic [AW-1:0]      exp_cmd[$];
  logic [31:0]        exp_beat[$];
  bit                 exp_fb[$];

  // Reference model: whole-frame view of the pixel stream.
  bit          m_sync = 0, m_buf = 0, m_ovf = 0;
  int          m_off = 0;
  logic [15:0] m_pix[$];

  function automatic logic [AW-1:0] mbase(input bit b);
    return b ? B1 : B0;
  endfunction

  task automatic m_burst();
    logic [15:0] lo, hi;
    exp_cmd.push_back(mbase(m_buf) + AW'(m_off));
    for (int i = 0; i < BW; i++) begin
      lo = (2*i   < m_pix.size()) ? m_pix[2*i]   : 16'h0;
      hi = (2*i+1 < m_pix.size()) ? m_pix[2*i+1] : 16'h0;
      exp_beat.push_back({hi, lo});
    end
    m_pix.delete();
    m_off += BW;
  endtask

  task automatic push_word(input logic [QUEUE_W-1:0] w);
    fq.push_back(w);
    if (!m_sync) begin
      if (w[QUEUE_MARKER_BIT]) begin m_sync = 1; m_off = 0; end
    end else if (w[QUEUE_MARKER_BIT]) begin
      if (m_pix.size() != 0) m_burst();
      exp_fb.push_back(m_buf);
      m_buf = !m_buf;
      m_off = 0;
    end else if (m_off >= FW) begin
      m_ovf = 1;
    end else begin
      m_pix.push_back(w[15:0]);
      if (m_pix.size() == 2*BW) m_burst();
    end
  endtask

  task automatic push_pix(input logic [15:0] v); push_word({1'b0, v}); endtask
  task automatic push_mark(); push_word(17'h10000); endtask

  // Driver / monitor state
  int  gap_pct = 0, stall_pct = 0, mode = 0, cmd_wait = 0;
  int  beat_cnt = 0;
  bit  seen_cmd = 0, hold_cmd = 0, hold_wr = 0;
  logic [AW-1:0] last_addr;
  logic [31:0]   last_data;

  task automatic monitor();
    if (RST) begin
      hold_cmd = 0; hold_wr = 0; seen_cmd = 0; beat_cnt = 0; cmd_wait = 0;
      return;
    end
    if (fifo_rd_en) chk("rd_when_empty", fifo_empty, 0);
    if (mem_cmd_valid || mem_wr_valid) chk("rd_in_burst", fifo_rd_en, 0);
    if (hold_cmd) begin
      chk("cmd_valid_hold", mem_cmd_valid, 1);
      chk("cmd_addr_hold", mem_cmd_addr, last_addr);
    end
    if (hold_wr) begin
      chk("wr_valid_hold", mem_wr_valid, 1);
      chk("wr_data_hold", mem_wr_data, last_data);
    end
    hold_cmd  = mem_cmd_valid && !mem_cmd_ready;
    hold_wr   = mem_wr_valid && !mem_wr_ready;
    last_addr = mem_cmd_addr;
    last_data = mem_wr_data;
    cmd_wait  = mem_cmd_valid ? cmd_wait + 1 : 0;
    if (mem_cmd_valid && mem_cmd_ready) begin
      if (seen_cmd) chk("beats_per_burst", beat_cnt, BW);
      seen_cmd = 1; beat_cnt = 0;
      chk("cmd_expected", mem_cmd_valid, exp_cmd.size() != 0);
      if (exp_cmd.size() != 0) chk("cmd_addr", mem_cmd_addr, exp_cmd.pop_front());
    end
    if (mem_wr_valid && mem_wr_ready) begin
      beat_cnt++;
      chk("beat_expected", mem_wr_valid, exp_beat.size() != 0);
      if (exp_beat.size() != 0) chk("beat_data", mem_wr_data, exp_beat.pop_front());
    end
    if (frame_done) begin
      chk("fd_expected", frame_done, exp_fb.size() != 0);
      if (exp_fb.size() != 0) chk("frame_buf", frame_buf, exp_fb.pop_front());
    end
  endtask

  initial begin : drv
    bit s_rd;
    fifo_empty = 1; fifo_data = '0; mem_cmd_ready = 0; mem_wr_ready = 0;
    forever begin
      @(negedge MemClk);
      s_rd = fifo_rd_en && !RST;
      monitor();
      @(posedge MemClk); #1;
      if (s_rd && !RST && fq.size() != 0) fifo_data = fq.pop_front();
      fifo_empty = (fq.size() == 0) || ($urandom_range(0, 99) < gap_pct);
      if (mode == 1) begin
        mem_cmd_ready = (cmd_wait >= 5);
        mem_wr_ready  = !mem_wr_ready;
      end else begin
        mem_cmd_ready = ($urandom_range(0, 99) >= stall_pct);
        mem_wr_ready  = ($urandom_range(0, 99) >= stall_pct);
      end
    end
  end

  task automatic apply_reset();
    @(posedge MemClk); #2;
    RST = 1;
    fq.delete(); exp_cmd.delete(); exp_beat.delete(); exp_fb.delete();
    m_sync = 0; m_buf = 0; m_off = 0; m_ovf = 0; m_pix.delete();
    @(negedge MemClk);
    chk("rst_rd_en",     fifo_rd_en,    0);
    chk("rst_cmd_valid", mem_cmd_valid, 0);
    chk("rst_cmd_addr",  mem_cmd_addr,  0);
    chk("rst_wr_valid",  mem_wr_valid,  0);
    chk("rst_wr_data",   mem_wr_data,   0);
    chk("rst_frame_done", frame_done,   0);
    chk("rst_frame_buf", frame_buf,     0);
    chk("rst_overflow",  overflow_err,  0);
    repeat (2) @(posedge MemClk);
    #2 RST = 0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((fq.size() + exp_cmd.size() + exp_beat.size() + exp_fb.size()) != 0 && n < 4000) begin
      @(negedge MemClk); n++;
    end
    repeat (20) @(negedge MemClk);
    chk(tag, fq.size() + exp_cmd.size() + exp_beat.size() + exp_fb.size(), 0);
    if (seen_cmd) chk("beats_per_burst", beat_cnt, BW);
  endtask

  initial begin
    RST = 1;
    apply_reset();

    // Pre-marker pixels dropped, first burst at buffer 0 base.
    push_pix(16'h0001); push_pix(16'h0002); push_mark();
    for (int i = 0; i < 16; i++) push_pix(16'h0100 + 16'(i));
    wait_idle("drain_first_burst");

    // Full burst then marker: flip to buffer 1.
    for (int i = 0; i < 16; i++) push_pix(16'($urandom));
    push_mark();
    for (int i = 0; i < 16; i++) push_pix(16'($urandom));
    wait_idle("drain_flip");

    // Partial burst flushed by a marker.
    push_pix(16'hAAAA); push_pix(16'hBBBB); push_pix(16'hCCCC); push_mark();
    wait_idle("drain_pad");

    // Stalled command, toggling beat ready.
    mode = 1;
    for (int i = 0; i < 16; i++) push_pix(16'($urandom));
    wait_idle("drain_stall");
    mode = 0;

    // Random frames, including empty ones, with FIFO gaps and backpressure.
    gap_pct = 30; stall_pct = 40;
    for (int f = 0; f < 8; f++) begin
      int n = $urandom_range(0, 40);
      if (f % 3 == 2) n = 0;
      for (int i = 0; i < n; i++) push_pix(16'($urandom));
      push_mark();
    end
    wait_idle("drain_random");
    gap_pct = 0; stall_pct = 0;

    // Oversized frame.
    chk("ovf_before", overflow_err, 0);
    for (int i = 0; i < FW*2 + 4; i++) push_pix(16'($urandom));
    push_mark();
    for (int i = 0; i < 6; i++) push_pix(16'($urandom));
    push_mark();
    wait_idle("drain_overflow");
    chk("ovf_after", overflow_err, m_ovf);

    // Reset in the middle of a burst.
    for (int i = 0; i < 16; i++) push_pix(16'($urandom));
    begin
      int n = 0;
      while (!mem_wr_valid && n < 500) begin @(negedge MemClk); n++; end
    end
    chk("reach_data", mem_wr_valid, 1);
    apply_reset();
    push_pix(16'h1234); push_mark();
    for (int i = 0; i < 16; i++) push_pix(16'h0200 + 16'(i));
    wait_idle("drain_post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
